// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the multi-cycle controller datapath:
//               PC-source select encodings, the NOP opcode and the default
//               address/data widths.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int unsigned CPU_AW = 8;
  localparam int unsigned CPU_DW = 8;

  // PC source select driven by the controller on Jmpmuxsel
  localparam logic [1:0] JMP_INC    = 2'b00;
  localparam logic [1:0] JMP_ABS    = 2'b01;
  localparam logic [1:0] JMP_RELNEG = 2'b10;
  localparam logic [1:0] JMP_RELPOS = 2'b11;

  localparam logic [7:0] OPC_NOP = 8'h00;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_unit_pc_next.sv
`default_nettype none
// ============================================================================
// Module      : pc_next
// Description : Combinational next-PC selection. Chooses between PC+1, an
//               absolute target from memory read data, and PC -/+ a 3-bit
//               magnitude taken from the registered instruction.
// Ports       : pc_i       current PC
//               jmp_sel_i  PC source select (JMP_* encodings)
//               mag_i      relative-jump magnitude (IR[2:0])
//               mem_rd_i   memory read data (absolute target)
//               pc_next_o  candidate next PC (modulo 2^AW)
// Revision    : 1.0  initial release
// ============================================================================
module pc_next
  import cpu_pkg::*;
#(
  parameter int unsigned AW = CPU_AW,
  parameter int unsigned DW = CPU_DW
) (
  input  logic [AW-1:0] pc_i,
  input  logic [1:0]    jmp_sel_i,
  input  logic [2:0]    mag_i,
  input  logic [DW-1:0] mem_rd_i,
  output logic [AW-1:0] pc_next_o
);

  logic [AW-1:0] w_abs;
  logic [AW-1:0] w_mag;

  // Fit the memory word onto the address width (truncate or zero-extend).
  generate
    if (DW >= AW) begin : g_abs_trunc
      assign w_abs = mem_rd_i[AW-1:0];
    end else begin : g_abs_zext
      assign w_abs = {{(AW-DW){1'b0}}, mem_rd_i};
    end
  endgenerate

  assign w_mag = {{(AW-3){1'b0}}, mag_i};

  always_comb begin
    pc_next_o = pc_i + 1'b1;
    unique case (jmp_sel_i)
      JMP_INC:    pc_next_o = pc_i + 1'b1;
      JMP_ABS:    pc_next_o = w_abs;
      JMP_RELNEG: pc_next_o = pc_i - w_mag;
      JMP_RELPOS: pc_next_o = pc_i + w_mag;
      default:    pc_next_o = pc_i + 1'b1;
    endcase
  end

endmodule : pc_next
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Fetch stage of the multi-cycle controller. Holds PC, IR and
//               MR, drives the unified memory address and presents IR to the
//               controller as instr. Sequencing is owned by the controller.
// Ports       : clk, reset (sync, active-high)
//               IRload / PCload / MRload  register load strobes
//               Jmpmuxsel                 PC source (see cpu_pkg JMP_*)
//               MemInst                   address select 0:PC 1:MR
//               mem_rd                    combinational read data
//               mem_addr, instr, pc, mr   outputs
// Options     : FETCH_STATS_EN adds fetch_count, jump_count (saturating
//               16-bit) and sticky stats_sat.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned AW       = CPU_AW,
  parameter int unsigned DW       = CPU_DW,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          IRload,
  input  logic          PCload,
  input  logic [1:0]    Jmpmuxsel,
  input  logic          MRload,
  input  logic          MemInst,
  input  logic [DW-1:0] mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] pc,
`ifdef FETCH_STATS_EN
  output logic [15:0]   fetch_count,
  output logic [15:0]   jump_count,
  output logic          stats_sat,
`endif
  output logic [AW-1:0] mr
);

  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q;
  logic [AW-1:0] mr_q;
  logic [AW-1:0] w_rd_addr;

  generate
    if (DW >= AW) begin : g_mr_trunc
      assign w_rd_addr = mem_rd[AW-1:0];
    end else begin : g_mr_zext
      assign w_rd_addr = {{(AW-DW){1'b0}}, mem_rd};
    end
  endgenerate

  pc_next #(
    .AW (AW),
    .DW (DW)
  ) u_pc_next (
    .pc_i      (pc_q),
    .jmp_sel_i (Jmpmuxsel),
    .mag_i     (ir_q[2:0]),
    .mem_rd_i  (mem_rd),
    .pc_next_o (pc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      ir_q <= DW'(OPC_NOP);
      mr_q <= '0;
    end else begin
      if (PCload) pc_q <= pc_d;
      if (IRload) ir_q <= mem_rd;
      if (MRload) mr_q <= w_rd_addr;
    end
  end

  assign mem_addr = MemInst ? mr_q : pc_q;
  assign instr    = ir_q;
  assign pc       = pc_q;
  assign mr       = mr_q;

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] jump_cnt_q,  jump_cnt_d;
  logic        sat_q;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    jump_cnt_d  = jump_cnt_q;
    if (IRload && (fetch_cnt_q != 16'hFFFF))
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (PCload && (Jmpmuxsel != JMP_INC) && (jump_cnt_q != 16'hFFFF))
      jump_cnt_d = jump_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      jump_cnt_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      jump_cnt_q  <= jump_cnt_d;
      // Sticky: once either counter pins at all-ones it stays flagged.
      sat_q       <= sat_q | (fetch_cnt_d == 16'hFFFF) | (jump_cnt_d == 16'hFFFF);
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign jump_count  = jump_cnt_q;
  assign stats_sat   = sat_q;
`endif

endmodule : fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Upstream stage of the multi-cycle controller: holds the program counter (PC), instruction register (IR) and memory-address register (MR).
- Drives the unified memory address, and the `instr` byte that the controller decodes.
- Executes the controller's IRload/PCload/MRload/MemInst/Jmpmuxsel commands: sequential fetch, absolute jumps, sign-magnitude relative jumps, and MR capture for indirect load/store.

Parameters:
- AW, 8, address/PC/MR width.
- DW, 8, memory data and instruction width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; overrides every load.
- IRload  input  1  capture mem_rd into IR.
- PCload  input  1  update PC per Jmpmuxsel.
- Jmpmuxsel  input  2  PC source: 00 PC+1, 01 mem_rd, 10 PC-mag, 11 PC+mag.
- MRload  input  1  capture mem_rd into MR.
- MemInst  input  1  address select: 0 PC, 1 MR.
- mem_rd  input  DW  memory read data, combinational from mem_addr.
- mem_addr  output  AW  memory address.
- instr  output  DW  IR contents, to controller.
- pc  output  AW  current PC.
- mr  output  AW  current MR.

Behaviour:
- Reset (synchronous, active-high, sampled on the clk edge):
  - PC=RESET_PC, IR=0 (NOP encoding), MR=0.
  - Reset has priority over all loads, including mid-instruction; no partial update survives.
- mem_addr is combinational:
  - MemInst=0: mem_addr=PC.
  - MemInst=1: mem_addr=MR.
- All register updates on the same edge use pre-edge PC/MR/IR values.
- IR:
  - IRload=1: IR<=mem_rd.
  - Otherwise IR holds.
  - instr=IR, so new value is visible one cycle after IRload (decode cycle).
- MR:
  - MRload=1: MR<=mem_rd[AW-1:0].
  - Otherwise MR holds.
- PC, when PCload=1:
  - 00: PC<=PC+1.
  - 01: PC<=mem_rd[AW-1:0] (absolute operand fetched at current PC).
  - 11: PC<=PC+{0,IR[2:0]}.
  - 10: PC<=PC-{0,IR[2:0]}.
  - Magnitude always comes from the registered IR[2:0], never from mem_rd.
- PC with PCload=0: holds; Jmpmuxsel is ignored.
- All PC/MR arithmetic is modulo 2^AW; no overflow flag.
- Boundary conditions:
  - PC=2^AW-1 with increment -> 0.
  - PC=2 with sub 5 -> 2^AW-3.
  - PC=250 with add 7 -> 1.
  - Magnitude 0 under 10/11: PC unchanged. This is legal, not an error.
- Simultaneous events:
  - IRload+PCload (fetch cycle): IR gets mem_rd at old PC; PC advances.
  - PCload+MRload (indirect first cycle): MR gets mem_rd at old PC; PC advances.
  - IRload+MRload together: both capture the same mem_rd.
- MemInst=1 with PCload=1 and Jmpmuxsel=01: PC loads data read from the MR address. This is permitted, not used by the controller.
- No internal FSM in the base block; cycle sequencing is owned by the controller.
- Latency: every update lands one edge after its command.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - Adds outputs fetch_count[15:0] and jump_count[15:0], both reset to 0.
  - fetch_count increments on each IRload.
  - jump_count increments on each PCload with Jmpmuxsel!=00.
  - Both counters saturate at 16'hFFFF.
  - Adds output stats_sat, sticky, set when either counter saturates; cleared only by reset.
- Undefined: ports and logic absent; base behaviour bit-identical.

Decomposition:
- Shared package (cpu_pkg):
  - JMP_INC=2'b00, JMP_ABS=2'b01, JMP_RELNEG=2'b10, JMP_RELPOS=2'b11.
  - NOP opcode 8'h00.
  - Default AW/DW.
- One sub-module: pc_next, the combinational next-PC mux/adder-subtractor taking PC, Jmpmuxsel, IR[2:0], mem_rd.
- The counters stay inline under the macro.

Test Plan:
- Reset then IRload+PCload with mem[0]=8'h61 -> next cycle instr=8'h61, pc=1, mem_addr=1.
- PC=8'hFF, PCload, Jmpmuxsel=00 -> pc=0 (wrap).
- IR=8'h65, PC=3, Jmpmuxsel=11 -> pc=8; IR=8'h6D, PC=3, Jmpmuxsel=10 -> pc=8'hFE.
- PC=4, mem[4]=8'h40, PCload+MRload then MemInst=1 -> mr=8'h40, pc=5, mem_addr=8'h40; then PCload=1, Jmpmuxsel=01 with mem[8'h40]=8'h22 -> pc=8'h22.
- reset asserted in the same cycle as IRload+PCload+MRload -> pc=RESET_PC, instr=0, mr=0.
- FETCH_STATS_EN: 3 fetches + 2 jumps -> fetch_count=3, jump_count=2; force fetch_count to 16'hFFFE, 3 more fetches -> holds 16'hFFFF, stats_sat=1.
